// File: rtl/ps2_key_matrix_if.sv
// Bundle of the PS/2 line, PPI row/column and map-ROM signals around the key matrix.
// Latency: none; this is only the port grouping.
// Backpressure: none; PS/2 and PPI traffic cannot be stalled.
interface ps2_key_matrix_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] ROW;
  logic [7:0] COLS;
  logic [8:0] MAP_CODE;
  logic       MAP_STB;
  logic [7:0] MAP;
  logic [7:0] RX_BYTE;
  logic       RX_VALID;
  logic       FRAME_ERR;

  // Keyboard/system side: drives the PS/2 lines and the row, answers the map lookup.
  modport master (
    output PS2_CLK, PS2_DAT, ROW, MAP,
    input  COLS, MAP_CODE, MAP_STB, RX_BYTE, RX_VALID, FRAME_ERR
  );

  // Matrix side: decodes frames, owns the matrix, asks the map ROM.
  modport slave (
    input  PS2_CLK, PS2_DAT, ROW, MAP,
    output COLS, MAP_CODE, MAP_STB, RX_BYTE, RX_VALID, FRAME_ERR
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 receiver and scancode decoder feeding an MSX key matrix read by PPI row select.
// Latency: RX_VALID to COLS change is 3 cycles; COLS follows ROW combinationally.
// Backpressure: none; every good byte is consumed the cycle it arrives.
module ps2_key_matrix #(
  parameter int NUM_ROWS    = 11,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic CLK,
  input logic RST,
  ps2_key_matrix_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          edge_any, fall;
  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    rx_byte;
  logic          rx_valid, frame_err;
  state_t        state;
  logic [2:0]    skip_left;
  logic [8:0]    map_code;
  logic          ev_pend, key_make, map_stb, clr_pend;
  logic          map_ok;
  logic [7:0]    matrix [NUM_ROWS];
  logic [7:0]    cols;

  // Two-flop synchronizers; idle PS/2 lines are high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.PS2_CLK; clk_s2 <= clk_s1;
      dat_s1 <= bus.PS2_DAT; dat_s2 <= dat_s1;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign edge_any = (clk_s2 != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = edge_any && !clk_s2;

  // Glitch filter on the synchronized PS/2 clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (edge_any) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Bit 10 arrives live on the data line; bits 0..9 are already in the shifter.
  assign frame = {dat_s2, shreg};

  // Frame receiver with start/stop/odd-parity check and mid-frame idle timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (!frame[0] && frame[10] && (^frame[9:1])) begin
            rx_byte  <= frame[8:1];
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shreg   <= {dat_s2, shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (edge_any || bit_cnt == 4'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Prefix decoder: turns byte stream into make/break key events for the map ROM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      skip_left <= '0;
      map_code  <= '0;
      ev_pend   <= 1'b0;
      key_make  <= 1'b0;
      map_stb   <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      ev_pend  <= 1'b0;
      clr_pend <= 1'b0;
      map_stb  <= ev_pend;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            case (rx_byte)
              8'hE0: state <= S_EXT;
              8'hF0: state <= S_BRK;
              8'hE1: begin state <= S_SKIP; skip_left <= 3'd7; end
              8'h00, 8'hFF: clr_pend <= 1'b1;
              8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
              default: begin map_code <= {1'b0, rx_byte}; key_make <= 1'b1; ev_pend <= 1'b1; end
            endcase
          end
          S_EXT: begin
            if (rx_byte == 8'hF0) begin
              state <= S_EXTBRK;
            end else begin
              state <= S_IDLE;
              if (rx_byte != 8'h12 && rx_byte != 8'h59) begin
                map_code <= {1'b1, rx_byte}; key_make <= 1'b1; ev_pend <= 1'b1;
              end
            end
          end
          S_BRK: begin
            state    <= S_IDLE;
            map_code <= {1'b0, rx_byte}; key_make <= 1'b0; ev_pend <= 1'b1;
          end
          S_EXTBRK: begin
            state <= S_IDLE;
            if (rx_byte != 8'h12 && rx_byte != 8'h59) begin
              map_code <= {1'b1, rx_byte}; key_make <= 1'b0; ev_pend <= 1'b1;
            end
          end
          S_SKIP: begin
            skip_left <= skip_left - 1'b1;
            if (skip_left == 3'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign map_ok = map_stb && bus.MAP[7] && (32'(bus.MAP[6:3]) < NUM_ROWS);

  // Matrix storage: a key bit goes low on make, high on break; 00/FF release everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 8'hFF;
    end else if (clr_pend) begin
      for (int r = 0; r < NUM_ROWS; r++) matrix[r] <= 8'hFF;
    end else if (map_ok) begin
      for (int r = 0; r < NUM_ROWS; r++)
        if (r[3:0] == bus.MAP[6:3]) matrix[r][bus.MAP[2:0]] <= ~key_make;
    end
  end

  // Asynchronous PPI read; unimplemented rows read as nothing pressed.
  always_comb begin
    cols = 8'hFF;
    for (int r = 0; r < NUM_ROWS; r++)
      if (r[3:0] == bus.ROW) cols = matrix[r];
  end

  assign bus.COLS      = cols;
  assign bus.MAP_CODE  = map_code;
  assign bus.MAP_STB   = map_stb;
  assign bus.RX_BYTE   = rx_byte;
  assign bus.RX_VALID  = rx_valid;
  assign bus.FRAME_ERR = frame_err;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: PS/2 frames in, matrix read back row by row against a reference model.
// Latency: checks the 3-cycle RX_VALID to COLS path explicitly once.
// Backpressure: none; frames are driven at PS/2-like pace.
module tb_ps2_key_matrix;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ps2_key_matrix_if bus();
  ps2_key_matrix dut (.CLK(CLK), .RST(RST), .bus(bus));

  // External map ROM: three fixed layout entries, everything else from a formula.
  function automatic logic [7:0] rom(input logic [8:0] c);
    case (c)
      9'h01C:  rom = 8'h96;
      9'h01B:  rom = 8'hA8;
      9'h175:  rom = 8'hC5;
      default: rom = {~(c[7] & c[1]), c[6:3] ^ {c[8], 3'b000}, c[2:0]};
    endcase
  endfunction
  always_comb bus.MAP = rom(bus.MAP_CODE);

  int errors = 0;
  int checks = 0;

  // Observed event counts.
  int rxv_cnt = 0, ferr_cnt = 0, stb_cnt = 0;
  logic [8:0] stb_code = '0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.RX_VALID)  rxv_cnt++;
      if (bus.FRAME_ERR) ferr_cnt++;
      if (bus.MAP_STB) begin stb_cnt++; stb_code = bus.MAP_CODE; end
    end
  end

  // Reference model: key state per row and prefix context as plain flags.
  logic [7:0] mdl [16];
  bit m_ext, m_brk;
  int m_skip;
  int exp_stb = 0, exp_rxv = 0, exp_ferr = 0;
  logic [8:0] exp_code = '0;
  logic [7:0] obs [16];

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mdl[r] = 8'hFF;
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_event(input bit ext, input logic [7:0] b, input bit make);
    logic [7:0] m;
    exp_stb++;
    exp_code = {ext, b};
    m = rom(exp_code);
    if (m[7] && m[6:3] < 4'd11) mdl[m[6:3]][m[2:0]] = ~make;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (b == 8'h00 || b == 8'hFF) begin
        for (int r = 0; r < 16; r++) mdl[r] = 8'hFF;
      end else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) model_event(0, b, 1);
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        if (b != 8'h12 && b != 8'h59) model_event(1, b, 1);
        m_ext = 0;
      end
    end else if (!m_ext) begin
      model_event(0, b, 0);
      m_brk = 0;
    end else begin
      if (b != 8'h12 && b != 8'h59) model_event(1, b, 0);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Drive the first n bits of an 11-bit frame, LSB first, data changed while clock high.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); bus.PS2_DAT = f[i];
      repeat (10) @(negedge CLK);
      bus.PS2_CLK = 1'b0;
      repeat (20) @(negedge CLK);
      bus.PS2_CLK = 1'b1;
      repeat (10) @(negedge CLK);
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
    repeat (30) @(negedge CLK);
    if (bad) exp_ferr++;
    else begin exp_rxv++; model_byte(b); end
  endtask

  task automatic sample_cols();
    for (int r = 0; r < 16; r++) begin
      @(negedge CLK); bus.ROW = r[3:0]; #1;
      obs[r] = bus.COLS;
    end
  endtask

  task automatic test_reset();
    bus.PS2_CLK = 1'b1; bus.PS2_DAT = 1'b1; bus.ROW = 4'd0; RST = 1'b1;
    model_reset();
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.MAP_CODE !== 9'h000) begin errors++; $display("FAIL reset_map_code got %h want 000", bus.MAP_CODE); end
    checks++; if (bus.MAP_STB !== 1'b0) begin errors++; $display("FAIL reset_map_stb got %b want 0", bus.MAP_STB); end
    checks++; if (bus.RX_BYTE !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", bus.RX_BYTE); end
    checks++; if (bus.RX_VALID !== 1'b0 || bus.FRAME_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got %b%b want 00", bus.RX_VALID, bus.FRAME_ERR); end
    sample_cols();
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== 8'hFF) begin errors++; $display("FAIL reset_cols row %0d got %h want FF", r, obs[r]); end
    end
  endtask

  task automatic test_make_latency();
    bit seen = 0;
    bus.ROW = 4'd2;
    fork
      send_byte(8'h1C, 0);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge CLK);
          if (bus.RX_VALID) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL make_rx_valid got none want pulse"); end
        else begin
          checks++; if (bus.RX_BYTE !== 8'h1C) begin errors++; $display("FAIL make_rx_byte got %h want 1C", bus.RX_BYTE); end
          repeat (2) @(negedge CLK);
          checks++; if (bus.COLS !== 8'hFF) begin errors++; $display("FAIL make_early got %h want FF", bus.COLS); end
          @(negedge CLK);
          checks++; if (bus.COLS !== 8'hBF) begin errors++; $display("FAIL make_lat3 got %h want BF", bus.COLS); end
        end
      end
    join
    sample_cols();
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== mdl[r]) begin errors++; $display("FAIL make_cols row %0d got %h want %h", r, obs[r], mdl[r]); end
    end
  endtask

  task automatic test_multi_key();
    send_byte(8'h1B, 0);
    sample_cols();
    checks++; if (obs[5] !== 8'hFE || obs[2] !== 8'hBF) begin
      errors++; $display("FAIL multi_hold got r5=%h r2=%h want FE BF", obs[5], obs[2]); end
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    sample_cols();
    checks++; if (obs[2] !== 8'hFF || obs[5] !== 8'hFE) begin
      errors++; $display("FAIL multi_break got r2=%h r5=%h want FF FE", obs[2], obs[5]); end
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== mdl[r]) begin errors++; $display("FAIL multi_cols row %0d got %h want %h", r, obs[r], mdl[r]); end
    end
  endtask

  task automatic test_extended();
    int stb0;
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    checks++; if (stb_code !== 9'h175) begin errors++; $display("FAIL ext_map_code got %h want 175", stb_code); end
    sample_cols();
    checks++; if (obs[8] !== 8'hDF) begin errors++; $display("FAIL ext_make got %h want DF", obs[8]); end
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    sample_cols();
    checks++; if (obs[8] !== 8'hFF) begin errors++; $display("FAIL ext_break got %h want FF", obs[8]); end
    stb0 = stb_cnt;
    send_byte(8'hE0, 0); send_byte(8'h12, 0);
    checks++; if (stb_cnt !== stb0) begin errors++; $display("FAIL ext_fake_shift got %0d strobes want %0d", stb_cnt, stb0); end
    checks++; if (stb_cnt !== exp_stb) begin errors++; $display("FAIL ext_stb_total got %0d want %0d", stb_cnt, exp_stb); end
  endtask

  task automatic test_frame_err_timeout();
    send_byte(8'h1C, 1);
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL perr_count got %0d want %0d", ferr_cnt, exp_ferr); end
    checks++; if (rxv_cnt !== exp_rxv) begin errors++; $display("FAIL perr_no_valid got %0d want %0d", rxv_cnt, exp_rxv); end
    sample_cols();
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== mdl[r]) begin errors++; $display("FAIL perr_cols row %0d got %h want %h", r, obs[r], mdl[r]); end
    end
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5);
    repeat (5000) @(negedge CLK);
    send_byte(8'h1C, 0);
    checks++; if (bus.RX_BYTE !== 8'h1C) begin errors++; $display("FAIL tmo_rx_byte got %h want 1C", bus.RX_BYTE); end
    checks++; if (ferr_cnt !== exp_ferr || rxv_cnt !== exp_rxv) begin
      errors++; $display("FAIL tmo_counts got err=%0d vld=%0d want %0d %0d", ferr_cnt, rxv_cnt, exp_ferr, exp_rxv); end
    sample_cols();
    checks++; if (obs[2] !== 8'hBF) begin errors++; $display("FAIL tmo_decode got %h want BF", obs[2]); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int stb0;
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    stb0 = stb_cnt;
    for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
    checks++; if (stb_cnt !== stb0) begin errors++; $display("FAIL pause_strobes got %0d want %0d", stb_cnt, stb0); end
    send_byte(8'h1C, 0);
    checks++; if (stb_code !== 9'h01C) begin errors++; $display("FAIL pause_next_code got %h want 01C", stb_code); end
    sample_cols();
    checks++; if (obs[2] !== 8'hBF) begin errors++; $display("FAIL pause_next_make got %h want BF", obs[2]); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1B, 0);
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    send_byte(8'hE0, 0);
    send_bits({1'b1, 1'b1, 8'h22, 1'b0}, 4);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    model_reset();
    checks++; if (bus.MAP_STB !== 1'b0 || bus.RX_BYTE !== 8'h00) begin
      errors++; $display("FAIL rst_mid_regs got stb=%b byte=%h want 0 00", bus.MAP_STB, bus.RX_BYTE); end
    sample_cols();
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== 8'hFF) begin errors++; $display("FAIL rst_mid_cols row %0d got %h want FF", r, obs[r]); end
    end
    send_byte(8'h1B, 0);
    checks++; if (stb_code !== 9'h01B) begin errors++; $display("FAIL rst_mid_idle got %h want 01B", stb_code); end
    send_byte(8'h1C, 0);
    sample_cols();
    checks++; if (obs[5] !== 8'hFE || obs[2] !== 8'hBF) begin
      errors++; $display("FAIL rst_mid_after got r5=%h r2=%h want FE BF", obs[5], obs[2]); end
    send_byte(8'h00, 0);
    sample_cols();
    for (int r = 0; r < 16; r++) begin
      checks++; if (obs[r] !== 8'hFF) begin errors++; $display("FAIL clear00 row %0d got %h want FF", r, obs[r]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int p;
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 99);
      if (p < 20) b = 8'hF0;
      else if (p < 32) b = 8'hE0;
      else if (p < 35) b = 8'h00;
      else if (p < 37) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      send_byte(b, 0);
      checks++; if (bus.RX_BYTE !== b) begin errors++; $display("FAIL rnd_rx_byte %0d got %h want %h", n, bus.RX_BYTE, b); end
      checks++; if (stb_cnt !== exp_stb || stb_code !== exp_code) begin
        errors++; $display("FAIL rnd_events %0d got %0d/%h want %0d/%h", n, stb_cnt, stb_code, exp_stb, exp_code); end
      sample_cols();
      for (int r = 0; r < 16; r++) begin
        checks++; if (obs[r] !== mdl[r]) begin errors++; $display("FAIL rnd_cols %0d row %0d got %h want %h", n, r, obs[r], mdl[r]); end
      end
    end
    checks++; if (rxv_cnt !== exp_rxv) begin errors++; $display("FAIL rnd_valid_total got %0d want %0d", rxv_cnt, exp_rxv); end
  endtask

  initial begin
    test_reset();
    test_make_latency();
    test_multi_key();
    test_extended();
    test_frame_err_timeout();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
- Keyboard-side counterpart of the system PPI port interface.
- Receives PS/2 scancode frames and decodes make/break and E0 prefixes into an 11x8 MSX key matrix.
- Returns the active-low column byte for the row currently selected on PPI port C[3:0]; that byte feeds the PPI port B input.
- Scancode-to-matrix translation comes from an external combinational map ROM, so layouts can change without touching this block.

Parameters:
- NUM_ROWS, 11, number of implemented matrix rows. Rows at or above this return 8'hFF.
- FILTER_LEN, 8, system-clock cycles PS2_CLK must hold a new level before the change is accepted.
- TIMEOUT_CYC, 4096, idle cycles mid-frame before the partial frame is discarded.

Ports:
- CLK  in  1  system clock (21.477 MHz nominal)
- RST  in  1  reset, asynchronous, active-high
- PS2_CLK  in  1  raw PS/2 clock, asynchronous
- PS2_DAT  in  1  raw PS/2 data, asynchronous
- ROW  in  4  row select from PPI port C[3:0]
- COLS  out  8  column byte for ROW; 0 = pressed
- MAP_CODE  out  9  {extended, scancode} presented to the map ROM
- MAP_STB  out  1  one-cycle strobe; MAP is sampled this cycle
- MAP  in  8  {valid, row[3:0], col[2:0]}, combinational from MAP_CODE
- RX_BYTE  out  8  last good received byte
- RX_VALID  out  1  one-cycle pulse per good byte
- FRAME_ERR  out  1  one-cycle pulse per rejected frame

Behaviour:
- Reset: matrix all 1s (COLS=8'hFF for every row), MAP_CODE=0, MAP_STB=0, RX_BYTE=0, RX_VALID=0, FRAME_ERR=0, decoder in IDLE, receiver idle.
- Applies at any time, including mid-frame and with keys held.

Input sync:
- PS2_CLK and PS2_DAT pass through 2-FF synchronizers.
- Synchronized PS2_CLK is filtered: the output level changes only after FILTER_LEN consecutive equal samples.
- A falling edge of the filtered clock samples synchronized PS2_DAT.

Receiver:
- 11-bit frame: start(0), 8 data LSB first, odd parity, stop(1).
- Bit counter 0..10. On the 11th bit:
  - start=0, stop=1 and odd parity over data+parity OK → RX_BYTE updated and RX_VALID pulses the next cycle.
  - Otherwise → FRAME_ERR pulses and the byte is dropped.
- Timeout counter clears on every filtered edge.
- If the bit counter is nonzero and TIMEOUT_CYC cycles pass with no edge, the bit counter returns to 0 silently.

Decoder FSM (advances on RX_VALID):
- IDLE:
  - E0 → EXT
  - F0 → BRK
  - E1 → SKIP, remaining=7
  - 00 or FF → clear whole matrix to 1s, stay IDLE
  - AA, FA, EE, FE → ignore
  - other → key event {ext=0, make}, stay IDLE
- EXT:
  - F0 → EXTBRK
  - 12 or 59 (fake shift) → IDLE, no event
  - other → {ext=1, make}, IDLE
- BRK: any byte → {ext=0, break}, IDLE
- EXTBRK:
  - 12 or 59 → IDLE, no event
  - other → {ext=1, break}, IDLE
- SKIP: decrement remaining on each byte; return to IDLE when it reaches 0. Pause generates no event.

Key event timing:
- Cycle after RX_VALID: MAP_CODE <= {ext, byte}.
- Following cycle: MAP_STB=1 and MAP is sampled.
- If MAP[7]=1 and MAP[6:3] < NUM_ROWS: on the next edge matrix[row][col] <= 0 for make, 1 for break.
- Otherwise no change.
- Total latency from RX_VALID to a visible COLS change: 3 cycles.
- Repeated make codes (typematic) rewrite 0, which is harmless.

Matrix read:
- COLS = matrix[ROW], combinational from ROW with no clock latency, because the PPI reads port B asynchronously.
- ROW >= NUM_ROWS → 8'hFF.
- A simultaneous matrix write and read of the same row returns the old value until the write edge.

Rules:
- Multiple keys may be held per row or across rows.
- There is no ghosting emulation.

Test Plan:
- Reset; sweep ROW 0..15 → COLS=8'hFF everywhere. Frame 1C; bench map gives 1C→{1,2,6} → ROW=2 gives COLS=8'hBF within 3 cycles of RX_VALID; other rows stay FF.
- Hold 1C, then send 1B (map {1,5,0}) → ROW=5 gives FE, ROW=2 gives BF. Send F0 1C → ROW=2 gives FF, ROW=5 still FE.
- E0 75, map 175→{1,8,5} → MAP_CODE=9'h175, ROW=8 gives DF. E0 F0 75 → FF. E0 12 → no MAP_STB.
- Frame 1C with bad parity → FRAME_ERR pulse, no RX_VALID, matrix unchanged. Send 5 bits then stop for 5000 cycles, then a clean 1C → decoded correctly.
- E1 14 77 E1 F0 14 F0 77 → no MAP_STB. The next 1C decodes as make.
- Hold three keys, assert RST for 1 cycle mid-frame → all rows FF, FSM IDLE. The next full frame decodes correctly. A received byte 00 clears all held keys.
